// File: rtl/lsu_mem_master.sv
// Load/store initiator: validates a core request, then runs one exec/busy/fin
// handshake with the word-array responder and reports data or an error code.
module lsu_mem_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_valid,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_mem_exec,
  output logic              o_mem_we,
  output logic [2:0]        o_mem_sel,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic [31:0]       i_mem_data,
  input  logic              i_mem_fin,
  input  logic              i_mem_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             seen_busy;
  logic             f3_illegal;
  logic             misaligned;
  logic             fin_ok;

  always_comb begin
    f3_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                 (i_funct3 == 3'b111) || (i_we && i_funct3[2]);
    misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  end

  // A fin is only trusted once busy has been seen, so a leftover fin from an
  // earlier access cannot complete a new one.
  assign fin_ok = i_mem_fin && seen_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      count      <= '0;
      seen_busy  <= 1'b0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_rdata    <= 32'h0;
      o_err      <= 1'b0;
      o_err_code <= 2'b00;
      o_mem_exec <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_sel  <= 3'b000;
      o_mem_addr <= '0;
      o_mem_data <= 32'h0;
    end else begin
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 2'b00;
      case (state)
        S_IDLE: begin
          if (i_req && o_ready) begin
            o_mem_we   <= i_we;
            o_mem_sel  <= i_funct3;
            o_mem_addr <= i_addr;
            o_mem_data <= i_wdata;
            o_ready    <= 1'b0;
            if (f3_illegal || misaligned) begin
              state      <= S_ERR;
              o_valid    <= 1'b1;
              o_err      <= 1'b1;
              o_err_code <= f3_illegal ? 2'b10 : 2'b01;
              o_rdata    <= 32'h0;
            end else begin
              state      <= S_ISSUE;
              count      <= '0;
              seen_busy  <= 1'b0;
              o_mem_exec <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (i_mem_busy) seen_busy <= 1'b1;
          if (fin_ok) begin
            state   <= S_RELEASE;
            o_valid <= 1'b1;
            o_rdata <= o_mem_we ? 32'h0 : i_mem_data;
          end else if (count == CNT_LAST) begin
            state      <= S_IDLE;
            o_ready    <= 1'b1;
            o_mem_exec <= 1'b0;
            o_valid    <= 1'b1;
            o_err      <= 1'b1;
            o_err_code <= 2'b11;
            o_rdata    <= 32'h0;
          end else begin
            count <= count + 1'b1;
          end
        end
        // Exec stays high for this one cycle so the responder can drop fin/busy.
        S_RELEASE: begin
          state      <= S_IDLE;
          o_ready    <= 1'b1;
          o_mem_exec <= 1'b0;
        end
        S_ERR: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          o_ready    <= 1'b1;
          o_mem_exec <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: byte-level reference memory predicts each
// response, a word-array responder model answers the handshake.
module tb_lsu_mem_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_mem_exec;
  logic        o_mem_we;
  logic [2:0]  o_mem_sel;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;
  logic        i_mem_fin;
  logic        i_mem_busy;

  always #5 clk = ~clk;

  lsu_mem_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_funct3   (i_funct3),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_rdata    (o_rdata),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_mem_exec (o_mem_exec),
    .o_mem_we   (o_mem_we),
    .o_mem_sel  (o_mem_sel),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data),
    .i_mem_fin  (i_mem_fin),
    .i_mem_busy (i_mem_busy)
  );

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] rdata;
    int          lat;
    int          exec_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  logic [7:0] ref_bytes [0:255];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference: memory is a flat little-endian byte array; outcome follows the
  // request rules directly.
  task automatic ref_model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dly, input bit no_resp,
                           output exp_t e);
    int     idx;
    int     nb;
    bit     illegal;
    longint val;
    idx = int'(addr[7:0]);
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    e.err = 1'b1; e.rdata = 32'h0; e.lat = 0; e.exec_cyc = 0;
    if (illegal) begin
      e.code = 2'b10;
    end else if ((idx % nb) != 0) begin
      e.code = 2'b01;
    end else if (no_resp || (3 + dly) > TO) begin
      e.code = 2'b11; e.lat = TO; e.exec_cyc = TO;
    end else begin
      e.err = 1'b0; e.code = 2'b00; e.lat = 3 + dly; e.exec_cyc = 4 + dly;
      if (we) begin
        for (int i = 0; i < nb; i++) ref_bytes[idx + i] = wdata[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < nb; i++) val += longint'(ref_bytes[idx + i]) << (8 * i);
        if (!f3[2] && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
          val = val - (longint'(1) << (8 * nb));
        e.rdata = val[31:0];
      end
    end
  endtask

  // Responder model: busy one cycle after exec, fin after resp_dly more cycles,
  // both cleared the cycle after fin, then waits for exec to drop.
  logic [31:0] resp_mem [0:63];
  logic [1:0]  ph;
  int          rcnt;
  int          resp_dly = 0;
  bit          resp_hung = 1'b0;
  bit          resp_stale = 1'b0;
  bit          clear_mem = 1'b0;
  logic        r_busy;
  logic        r_fin;
  logic [31:0] r_data;

  assign i_mem_fin  = resp_stale ? 1'b1 : r_fin;
  assign i_mem_busy = resp_stale ? 1'b0 : r_busy;
  assign i_mem_data = r_data;

  function automatic logic [31:0] resp_load(input logic [31:0] w, input logic [2:0] sel, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sel)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] resp_store(input logic [31:0] w, input logic [2:0] sel,
                                             input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (sel[1:0])
      2'b00:   r[8*off +: 8] = d[7:0];
      2'b01:   if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ph <= 2'd0; r_busy <= 1'b0; r_fin <= 1'b0; r_data <= 32'h0; rcnt <= 0;
    end else begin
      if (clear_mem) for (int i = 0; i < 64; i++) resp_mem[i] <= 32'h0;
      case (ph)
        2'd0: if (o_mem_exec && !resp_hung && !resp_stale) begin
          r_busy <= 1'b1; rcnt <= resp_dly; ph <= 2'd1;
        end
        2'd1: if (rcnt == 0) begin
          r_fin <= 1'b1; ph <= 2'd2;
          if (o_mem_we) begin
            resp_mem[o_mem_addr[7:2]] <= resp_store(resp_mem[o_mem_addr[7:2]], o_mem_sel, o_mem_addr[1:0], o_mem_data);
            r_data <= $urandom;
          end else begin
            r_data <= resp_load(resp_mem[o_mem_addr[7:2]], o_mem_sel, o_mem_addr[1:0]);
          end
        end else begin
          rcnt <= rcnt - 1;
        end
        2'd2: begin r_busy <= 1'b0; r_fin <= 1'b0; ph <= 2'd3; end
        default: if (!o_mem_exec) ph <= 2'd0;
      endcase
    end
  end

  // Monitor: measures latency and exec duration, pops and compares on o_valid.
  initial begin
    bit          tracking;
    int          lat_cnt;
    int          exec_cnt;
    logic [31:0] last_rdata;
    exp_t        e;
    tracking = 0; lat_cnt = 0; exec_cnt = 0; last_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!i_reset_n) begin
        tracking = 0; lat_cnt = 0; exec_cnt = 0; last_rdata = 32'h0;
      end else begin
        if (!tracking) check_output("exec_idle", {31'h0, o_mem_exec}, 32'h0);
        if (tracking) lat_cnt++;
        if (o_mem_exec) exec_cnt++;
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_valid", {31'h0, o_valid}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_output("err", {31'h0, o_err}, {31'h0, e.err});
            check_output("err_code", {30'h0, o_err_code}, {30'h0, e.code});
            check_output("rdata", o_rdata, e.rdata);
            check_output("latency", lat_cnt - 1, e.lat);
            check_output("exec_cycles", exec_cnt, e.exec_cyc);
            last_rdata = e.rdata;
          end
          tracking = 0;
          done_cnt++;
        end else begin
          check_output("err_idle", {29'h0, o_err, o_err_code}, 32'h0);
          check_output("rdata_hold", o_rdata, last_rdata);
        end
        if (i_req && o_ready) begin
          tracking = 1; lat_cnt = 0; exec_cnt = 0;
        end
      end
    end
  end

  task automatic apply_stimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int dly, input bit hung, input bit stale);
    exp_t e;
    int   start;
    ref_model(we, f3, addr, wdata, dly, hung || stale, e);
    exp_q.push_back(e);
    resp_dly = dly; resp_hung = hung; resp_stale = stale;
    start = done_cnt;
    @(posedge clk); #1;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(posedge clk); #1;
    i_req = 1'b0;
    for (int n = 0; n < 40 && done_cnt == start; n++) @(posedge clk);
    check_output("completion", done_cnt - start, 32'd1);
    if (done_cnt == start) exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    resp_hung = 1'b0; resp_stale = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    i_reset_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ready", {31'h0, o_ready}, 32'd1);
    check_output("rst_valid", {31'h0, o_valid}, 32'd0);
    check_output("rst_err", {29'h0, o_err, o_err_code}, 32'd0);
    check_output("rst_rdata", o_rdata, 32'h0);
    check_output("rst_exec", {30'h0, o_mem_exec, o_mem_we}, 32'd0);
    check_output("rst_sel", {29'h0, o_mem_sel}, 32'd0);
    check_output("rst_addr", o_mem_addr, 32'h0);
    check_output("rst_data", o_mem_data, 32'h0);
    i_reset_n = 1'b1; clear_mem = 1'b1;
    @(posedge clk); #1;
    clear_mem = 1'b0;

    $display("[TB] directed transactions");
    apply_stimulus(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    apply_stimulus(0, 3'b010, 32'h10, 32'h0, 0, 0, 0);
    apply_stimulus(1, 3'b000, 32'h8, 32'h123456AB, 0, 0, 0);
    apply_stimulus(0, 3'b100, 32'h8, 32'h0, 0, 0, 0);
    apply_stimulus(1, 3'b000, 32'h21, 32'h00000080, 1, 0, 0);
    apply_stimulus(0, 3'b000, 32'h21, 32'h0, 2, 0, 0);
    apply_stimulus(0, 3'b001, 32'h3, 32'h0, 0, 0, 0);
    apply_stimulus(1, 3'b010, 32'h6, 32'h55AA55AA, 0, 0, 0);
    apply_stimulus(0, 3'b011, 32'h0, 32'h0, 0, 0, 0);
    apply_stimulus(1, 3'b100, 32'h0, 32'h0, 0, 0, 0);
    apply_stimulus(0, 3'b010, 32'h10, 32'h0, 0, 1, 0);
    apply_stimulus(0, 3'b010, 32'h10, 32'h0, 0, 0, 0);
    apply_stimulus(0, 3'b010, 32'h8, 32'h0, TO - 3, 0, 0);
    apply_stimulus(0, 3'b001, 32'h8, 32'h0, TO - 2, 0, 0);
    apply_stimulus(0, 3'b010, 32'h4, 32'h0, 0, 0, 1);

    $display("[TB] reset during issue");
    resp_hung = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0;
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_output("mid_rst_exec", {31'h0, o_mem_exec}, 32'd0);
    check_output("mid_rst_ready", {31'h0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_reset_n = 1'b1; resp_hung = 1'b0;
    repeat (2) @(posedge clk);
    apply_stimulus(0, 3'b010, 32'h10, 32'h0, 0, 0, 0);

    $display("[TB] random transactions");
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                     $urandom_range(0, 3), 0, 0);
    end

    repeat (5) @(posedge clk);
    check_output("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the CPU core and the word-array memory responder.
- Accepts one RISC-V load/store request from the core. Checks funct3 and alignment, then drives the responder's exec/we/sel handshake.
- Returns read data, a completion pulse and an error code to the core.
- Single outstanding transaction; a bounded wait counter guards against a hung responder.

Parameters:
TIMEOUT_CYCLES, 16, max ISSUE cycles waiting for i_mem_fin before aborting (must be >=4)
ADDR_W, 32, address width forwarded to memory

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_req  in  1  core request strobe; accepted when i_req && o_ready
i_we  in  1  1=store, 0=load
i_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_addr  in  ADDR_W  byte address
i_wdata  in  32  store data
o_ready  out  1  high only in IDLE
o_valid  out  1  one-cycle completion pulse
o_rdata  out  32  load result (0 for stores/errors), held until next o_valid
o_err  out  1  qualifies o_valid: transaction failed
o_err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 ok
o_mem_exec  out  1  responder exec
o_mem_we  out  1  responder write enable
o_mem_sel  out  3  responder size select (000 b, 001 h, 010 w, 100 bu, 101 hu)
o_mem_addr  out  ADDR_W  responder address
o_mem_data  out  32  responder write data
i_mem_data  in  32  responder read data
i_mem_fin  in  1  responder finished
i_mem_busy  in  1  responder busy

Behaviour:
Reset (async, i_reset_n=0):
- State=IDLE, counter=0, seen_busy=0.
- Outputs: o_ready=1, o_valid=0, o_err=0, o_err_code=00, o_rdata=0.
- o_mem_exec=0, o_mem_we=0, o_mem_sel=000, o_mem_addr=0, o_mem_data=0.
- Reset mid-transaction drops exec immediately. The responder's own reset brings it back in step.

Acceptance and checks:
- On accept, latch we, funct3, addr and wdata into o_mem_*; sel = funct3.
- Illegal: funct3 in {011,110,111}, or a store with funct3[2]=1 -> code 10.
- Misaligned (legal funct3 only): half with addr[0]=1, or word with addr[1:0]!=0 -> code 01.
- Illegal/misaligned: no memory access; next state ERR.
- Otherwise next state ISSUE, counter=0, seen_busy=0.

States:
- ERR: one cycle. o_valid=1, o_err=1, code set, o_rdata=0 -> IDLE.
- ISSUE: o_mem_exec=1; counter increments each cycle.
  - seen_busy is set by i_mem_busy=1.
  - i_mem_fin counts only when seen_busy is already set (registered), so a stale fin is ignored.
  - On valid fin: o_rdata<=i_mem_data (load) or 0 (store) -> RELEASE.
  - When counter reaches TIMEOUT_CYCLES-1 without valid fin: o_mem_exec<=0, o_valid=1, o_err=1, code 11 -> IDLE.
  - A fin in the same cycle as expiry wins (normal completion).
- RELEASE: one cycle. o_mem_exec held 1 so the responder clears fin/busy. o_valid=1, o_err=0, code 00 -> IDLE, exec=0.
- IDLE: o_mem_exec=0. o_mem_* hold their last values. i_mem_fin/busy ignored.

Other rules:
- o_valid/o_err/o_err_code are registered and are pulses. o_err_code returns to 00 when o_valid drops.
- Requests while o_ready=0 are ignored; the core must hold them.
- Nominal latency (responder busy 1 cycle after exec, fin 1 cycle later): accept edge -> o_valid high 3 cycles later. Next accept possible the cycle after o_valid.
- Read data is passed through; sign/zero extension is done by the responder.

Test Plan:
- LW at 0x10, mem word 4 = 0xDEADBEEF -> o_valid 3 cycles after accept; o_rdata=0xDEADBEEF, o_err=0; exec high exactly 4 cycles.
- SB addr 0x8, wdata 0x123456AB, then LBU 0x8 -> mem word 2 [7:0]=0xAB; load o_rdata=0x000000AB. LB of 0x80 -> 0xFFFFFF80.
- LH addr 0x3 -> o_valid next cycle, o_err=1, code 01, o_mem_exec never asserted. SW addr 0x6 -> same.
- funct3=011 load, and store funct3=100 -> o_valid, o_err=1, code 10, no exec.
- Responder never asserts busy/fin, TIMEOUT_CYCLES=16 -> o_valid with code 11 on cycle 16 after accept; exec low after; next request accepted.
- i_reset_n low during ISSUE -> o_mem_exec=0 asynchronously, o_ready=1. i_mem_fin=1 held from before the request with busy=0 -> not accepted as completion.
